// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line and frame config in, recovered byte and status strobes out.
interface uart_rx_if;
  logic       rx_in;
  logic       parity_en;
  logic       parity_type;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       stop_err;
  logic       busy;

  modport master (
    output rx_in, parity_en, parity_type,
    input  data_out, data_valid, parity_err, stop_err, busy
  );

  modport slave (
    input  rx_in, parity_en, parity_type,
    output data_out, data_valid, parity_err, stop_err, busy
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop synchronizer, majority-of-three bit sampling,
// optional parity and stop-bit checks, one-cycle result strobes.
//
//   state  | meaning
//   IDLE   | line idle, waiting for rx_s low
//   START  | inside start bit, glitch check at mid-bit
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | checking the optional parity bit
//   STOP   | sampling the stop bit, result issued on exit
module uart_rx #(
  parameter int PRESCALE = 8
) (
  input  logic     clk,
  input  logic     rst,
  uart_rx_if.slave bus
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] SAMP_A = CW'(PRESCALE/2 - 1);
  localparam logic [CW-1:0] SAMP_B = CW'(PRESCALE/2);
  localparam logic [CW-1:0] SAMP_C = CW'(PRESCALE/2 + 1);
  localparam logic [CW-1:0] LAST   = CW'(PRESCALE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t        state_q;
  logic          sync1_q, sync2_q;
  logic [CW-1:0] edge_q;
  logic [2:0]    bit_cnt_q;
  logic          samp_a_q, samp_b_q, bit_q;
  logic [7:0]    shift_q;
  logic          pen_q, ptype_q, perr_q;
  logic [7:0]    data_out_q;
  logic          dv_q, pe_q, se_q, busy_q;

  logic rx_s, maj, bit_val, end_of_bit;

  assign rx_s       = sync2_q;
  assign maj        = (samp_a_q & samp_b_q) | (samp_a_q & rx_s) | (samp_b_q & rx_s);
  // Third sample may coincide with the last cycle of the bit when PRESCALE is 4.
  assign bit_val    = (edge_q == SAMP_C) ? maj : bit_q;
  assign end_of_bit = (edge_q == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      edge_q     <= '0;
      bit_cnt_q  <= '0;
      samp_a_q   <= 1'b0;
      samp_b_q   <= 1'b0;
      bit_q      <= 1'b0;
      shift_q    <= '0;
      pen_q      <= 1'b0;
      ptype_q    <= 1'b0;
      perr_q     <= 1'b0;
      data_out_q <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync1_q <= bus.rx_in;
      sync2_q <= sync1_q;
      dv_q    <= 1'b0;
      pe_q    <= 1'b0;
      se_q    <= 1'b0;

      if (state_q != IDLE) edge_q <= end_of_bit ? '0 : edge_q + CW'(1);
      if (edge_q == SAMP_A) samp_a_q <= rx_s;
      if (edge_q == SAMP_B) samp_b_q <= rx_s;
      if (edge_q == SAMP_C) bit_q    <= maj;

      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q   <= START;
            edge_q    <= CW'(1);
            busy_q    <= 1'b1;
            pen_q     <= bus.parity_en;
            ptype_q   <= bus.parity_type;
            perr_q    <= 1'b0;
            bit_cnt_q <= '0;
          end
        end
        START: begin
          if (edge_q == SAMP_C && maj) begin
            state_q <= IDLE;
            edge_q  <= '0;
            busy_q  <= 1'b0;
          end else if (end_of_bit) begin
            state_q <= DATA;
          end
        end
        DATA: begin
          if (end_of_bit) begin
            shift_q   <= {bit_val, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= pen_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (end_of_bit) begin
            perr_q  <= bit_val ^ (^shift_q) ^ ptype_q;
            state_q <= STOP;
          end
        end
        STOP: begin
          if (end_of_bit) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (!perr_q && bit_val) begin
              data_out_q <= shift_q;
              dv_q       <= 1'b1;
            end else begin
              pe_q <= perr_q;
              se_q <= ~bit_val;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = dv_q;
  assign bus.parity_err = pe_q;
  assign bus.stop_err   = se_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frame driver pushes the expected result, a negedge
// monitor pops and compares whenever a result strobe appears.
module tb_uart_rx;
  localparam int P = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  uart_rx_if bus();

  uart_rx #(.PRESCALE(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       v;
    logic       pe;
    logic       se;
    logic [7:0] dout;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  exp_t       mon_e;
  logic [7:0] last_good = 8'h00;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst && (bus.data_valid || bus.parity_err || bus.stop_err)) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pulse: got dv=%0b pe=%0b se=%0b at cycle %0d, expected no pulse",
                 bus.data_valid, bus.parity_err, bus.stop_err, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("data_valid", int'(bus.data_valid), int'(mon_e.v));
        check("parity_err", int'(bus.parity_err), int'(mon_e.pe));
        check("stop_err", int'(bus.stop_err), int'(mon_e.se));
        check("data_out", int'(bus.data_out), int'(mon_e.dout));
        check("pulse_cycle", cyc, mon_e.cyc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    bus.rx_in = 1'b1;
    tick(n);
  endtask

  task automatic at_cycle(input int t, input int c);
    while (cyc < t + c) tick(1);
  endtask

  // Reference: frame result depends only on parity agreement and the stop bit level.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptype,
                            input logic flip, input logic stop_bit, input logic churn);
    int   t, n;
    logic pbit, b;
    exp_t e;
    t    = cyc;
    n    = pen ? 11 : 10;
    pbit = (^d) ^ ptype ^ flip;
    e.pe = pen & flip;
    e.se = ~stop_bit;
    e.v  = ~e.pe & ~e.se;
    if (e.v) last_good = d;
    e.dout = last_good;
    e.cyc  = t + 2 + n * P;
    sb.push_back(e);
    bus.parity_en   = pen;
    bus.parity_type = ptype;
    for (int i = 0; i < n; i++) begin
      if (i == 0)               b = 1'b0;
      else if (i <= 8)          b = d[i-1];
      else if (pen && i == 9)   b = pbit;
      else                      b = stop_bit;
      bus.rx_in = b;
      if (churn && i >= 1) begin
        bus.parity_en   = 1'($urandom_range(0, 1));
        bus.parity_type = 1'($urandom_range(0, 1));
      end
      tick(P);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int         t;
    logic [7:0] rd;
    bus.rx_in       = 1'b1;
    bus.parity_en   = 1'b0;
    bus.parity_type = 1'b0;
    rst             = 1'b0;
    tick(3);
    check("reset_data_out", int'(bus.data_out), 0);
    check("reset_valid", int'(bus.data_valid), 0);
    check("reset_parity_err", int'(bus.parity_err), 0);
    check("reset_stop_err", int'(bus.stop_err), 0);
    check("reset_busy", int'(bus.busy), 0);
    rst = 1'b1;
    tick(5);

    t = cyc;
    fork
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      begin
        at_cycle(t, 2);  check("busy_c2", int'(bus.busy), 0);
        at_cycle(t, 3);  check("busy_c3", int'(bus.busy), 1);
        at_cycle(t, 81); check("busy_c81", int'(bus.busy), 1);
        at_cycle(t, 82); check("busy_c82", int'(bus.busy), 0);
        check("valid_c82", int'(bus.data_valid), 1);
      end
    join
    idle(5);

    send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    idle(3);
    send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(3);
    send_frame(8'h55, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(6);

    t = cyc;
    bus.rx_in = 1'b0;
    tick(2);
    bus.rx_in = 1'b1;
    at_cycle(t, 3);  check("glitch_busy_high", int'(bus.busy), 1);
    at_cycle(t, 12); check("glitch_busy_low", int'(bus.busy), 0);
    idle(4);
    send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(3);

    send_frame(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(6);

    rd = 8'h5A;
    bus.parity_en = 1'b0;
    bus.rx_in = 1'b0;
    tick(P);
    for (int i = 0; i < 4; i++) begin
      bus.rx_in = rd[i];
      tick(P);
    end
    bus.rx_in = rd[4];
    tick(P / 2);
    check("pre_reset_busy", int'(bus.busy), 1);
    rst = 1'b0;
    #1;
    check("midrst_data_out", int'(bus.data_out), 0);
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_valid", int'(bus.data_valid), 0);
    check("midrst_errs", int'({bus.parity_err, bus.stop_err}), 0);
    last_good = 8'h00;
    bus.rx_in = 1'b1;
    tick(3);
    rst = 1'b1;
    idle(4);
    send_frame(8'h81, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int k = 0; k < 20; k++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      if (gap > 0) idle(gap);
      send_frame(8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) != 0), 1'b1);
    end
    idle(2);

    for (int i = 0; i < 1000 && sb.size() != 0; i++) tick(1);
    check("scoreboard_drained", sb.size(), 0);
    tick(P * 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
# uart_rx

Oversampling UART receiver. It recovers 8-bit frames from the serial line driven by the UART transmitter's `data_out`. It checks optional parity and the stop bit, then presents each good byte with a one-cycle `data_valid` strobe. It is the receive half of the UART and the downstream consumer of the transmitter's serial stream.

## Interface

Parameters:
- `PRESCALE`, default 8: clock cycles per serial bit (oversampling factor). Legal range is 4–32.

Ports:
- `clk`  in  1  Sole clock; all state updates on its rising edge.
- `rst`  in  1  Reset, asynchronous, active-low.
- `rx_in`  in  1  Serial line. Idle high. Asynchronous to `clk`.
- `parity_en`  in  1  1 = frame carries a parity bit after the data bits.
- `parity_type`  in  1  0 = even, 1 = odd. Same convention as the transmitter.
- `data_out`  out  8  Last correctly received byte.
- `data_valid`  out  1  One-cycle pulse: `data_out` was just updated.
- `parity_err`  out  1  One-cycle pulse: parity mismatch in the frame just ended.
- `stop_err`  out  1  One-cycle pulse: stop bit sampled low.
- `busy`  out  1  High while a frame is being received.

## Operation

- `rx_in` passes through a 2-flop synchronizer; `rx_s` is the synchronizer output. All logic below uses `rx_s` only.
- Frame format:
  - start bit (0)
  - 8 data bits, LSB first
  - parity bit, present only if `parity_en`
  - stop bit (1)
- `parity_en` and `parity_type` are sampled when the start bit is detected and held for the frame.
- Each bit occupies `PRESCALE` cycles, tracked by `edge_cnt` running 0..`PRESCALE`-1.
- Bit value is the majority of `rx_s` at `edge_cnt` = `PRESCALE`/2-1, `PRESCALE`/2 and `PRESCALE`/2+1.
- A separate bit counter tracks data bits 0..7.
- FSM states and transitions:
  - IDLE: when `rx_s`=0, the current cycle counts as `edge_cnt`=0 of the start bit. Go to START.
  - START: at `edge_cnt` = `PRESCALE`/2+1, if the majority is 1, the start bit was a glitch. Go to IDLE immediately, with no outputs and no error. Otherwise, at `edge_cnt` = `PRESCALE`-1, go to DATA.
  - DATA: shift the majority bit in, LSB first. After bit 7 ends, go to PARITY if `parity_en`, else to STOP.
  - PARITY: compare the received bit to the computed parity:
    - even: XOR of the data bits
    - odd: inverted XOR
    
    Record a mismatch. Go to STOP at the end of the bit.
  - STOP: sample the stop bit. At `edge_cnt` = `PRESCALE`-1, go to IDLE and issue the frame result in the next cycle.
- Frame result (registered, one cycle):
  - no errors: load `data_out`, pulse `data_valid`
  - any error: `data_out` unchanged, no `data_valid`; pulse `parity_err` and/or `stop_err`. Both can pulse together.
- `busy` = 1 in START, DATA, PARITY and STOP; 0 in IDLE.

## Timing

- Reset values: `data_out`=0, all pulses 0, `busy`=0, FSM in IDLE, counters 0, synchronizer flops 1.
- Latency: let cycle 0 be the cycle whose rising edge first captures `rx_in`=0.
  - `busy` rises in cycle 3.
  - Frame spans cycles 2 .. 2+N·`PRESCALE`-1, where N is 10 without parity or 11 with parity.
  - `data_valid` or error pulses occur in cycle 2+N·`PRESCALE`.
  - With `PRESCALE`=8 and no parity, the pulse is in cycle 82.
- Back-to-back frames: the FSM is in IDLE in the result cycle. A start bit whose `rx_s` goes low in that cycle is detected as `edge_cnt`=0. No idle gap is required beyond the stop bit.
- A low stop bit is reported via `stop_err`. The receiver still returns to IDLE and treats any continued low as a new start bit.
- Asserting `rst` mid-frame clears everything immediately; the partial frame is discarded with no pulses.
- Changes on `parity_en` or `parity_type` mid-frame have no effect on the frame in progress.

## Test plan

- `PRESCALE`=8, no parity, send 0xA5 → `data_out`=0xA5, `data_valid` one cycle at cycle 82, no error pulses; `busy` high in cycles 3–81.
- Parity enabled, even, send 0x3C with parity bit 0 → `data_valid`, `data_out`=0x3C. Then send 0x3C with parity bit 1 → `parity_err` pulse, no `data_valid`, `data_out` stays 0x3C.
- Odd parity, send 0x01 with parity 0, then send 0x55 with stop bit 0 → first frame valid (`data_out`=0x01); second frame gives `stop_err` pulse only, `data_out` stays 0x01.
- Glitch: `rx_in` low for 2 cycles, then high → `busy` high briefly, returns to IDLE, no pulses. A following frame 0x7E is received correctly.
- Back-to-back 0x00 then 0xFF, with no gap after the stop bit → two `data_valid` pulses exactly 10·`PRESCALE` cycles apart, with values 0x00 then 0xFF.
- Assert `rst` during data bit 4 of a frame → all outputs at reset values immediately, no pulse. The next complete frame 0x81 is received correctly.
